// File: rtl/imu_ram_writer.sv
// Packs IMU sample frames from a valid/ready word stream into a circular buffer of RAM slots
// and shares the single RAM port with host word reads. The stream has priority; a starved host forces a stall.
//
// state | meaning
// IDLE  | between frames, word_idx == 0
// FILL  | writing words of the current frame into head_slot
// DROP  | frame overran its slot; beats accepted but discarded up to s_last
module imu_ram_writer #(
    parameter int WORDS_PER_SAMPLE = 8,
    parameter int NUM_SLOTS        = 32,
    parameter int STARVE_LIM       = 4
) (
    input  logic                          c,
    input  logic                          rst,
    input  logic [31:0]                   s_d,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [7:0]                    ram_addr,
    output logic                          ram_wr,
    output logic [31:0]                   ram_d,
    input  logic [31:0]                   ram_q,
    input  logic                          host_rd_req,
    input  logic [7:0]                    host_rd_addr,
    output logic                          host_rd_busy,
    output logic [31:0]                   host_rd_data,
    output logic                          host_rd_valid,
    output logic [$clog2(NUM_SLOTS)-1:0]  head_slot,
    output logic [15:0]                   sample_cnt,
    output logic                          sample_done,
    output logic                          frame_err
);

    localparam int IW = $clog2(WORDS_PER_SAMPLE);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   word_idx;
    logic [SW+IW-1:0] wr_addr;
    logic            beat, grant, last_word;
    logic            wr_en, commit, frame_bad;
    logic            host_pend, host_g1;
    logic [7:0]      host_addr;
    logic [CW-1:0]   starve_cnt;

    assign beat         = s_valid & s_ready;
    assign grant        = host_pend & ~beat;
    assign last_word    = (word_idx == IW'(WORDS_PER_SAMPLE - 1));
    assign wr_addr      = {head_slot, word_idx};
    assign host_rd_busy = host_pend | host_g1;

    always_ff @(posedge c) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FILL: begin
                if (beat) begin
                    if (s_last)         state_nxt = IDLE;
                    else if (last_word) state_nxt = DROP;
                    else                state_nxt = FILL;
                end
            end
            DROP:    if (beat && s_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = beat && (state != DROP);
        commit    = wr_en && s_last && last_word;
        frame_bad = beat && s_last && ((state == DROP) || !last_word);
        ram_wr    = wr_en;
        ram_d     = wr_en ? s_d : 32'd0;
        ram_addr  = grant ? host_addr : 8'(wr_addr);
    end

    always_ff @(posedge c) begin
        if (rst) begin
            word_idx      <= '0;
            head_slot     <= '0;
            sample_cnt    <= '0;
            sample_done   <= 1'b0;
            frame_err     <= 1'b0;
            s_ready       <= 1'b0;
            host_pend     <= 1'b0;
            host_g1       <= 1'b0;
            host_addr     <= '0;
            host_rd_data  <= '0;
            host_rd_valid <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            sample_done <= commit;
            frame_err   <= frame_bad;

            // In DROP the index parks at the last word until s_last closes the frame.
            if (beat) begin
                if (s_last)
                    word_idx <= '0;
                else if ((state != DROP) && !last_word)
                    word_idx <= word_idx + 1'b1;
            end

            if (commit) begin
                head_slot  <= head_slot + 1'b1;
                sample_cnt <= sample_cnt + 16'd1;
            end

            if (host_rd_req && !host_rd_busy) begin
                host_pend <= 1'b1;
                host_addr <= host_rd_addr;
            end else if (grant) begin
                host_pend <= 1'b0;
            end

            host_g1       <= grant;
            host_rd_valid <= host_g1;
            if (host_g1)
                host_rd_data <= ram_q;

            if (host_pend && !grant) starve_cnt <= starve_cnt + 1'b1;
            else                     starve_cnt <= '0;

            // The stall cycle has no beat, so the pending read is granted in it.
            s_ready <= !(host_pend && !grant && (starve_cnt == CW'(STARVE_LIM - 1)));
        end
    end

endmodule

// File: tb/tb_imu_ram_writer.sv
// Directed bench for imu_ram_writer: behavioural RAM, write/read scoreboards and a
// cycle-delayed model of head_slot, sample_cnt and the commit/error pulses.
module tb_imu_ram_writer;

    localparam int WPS = 8;
    localparam int NS  = 32;

    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_d = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] ram_d;
    logic [31:0] ram_q;
    logic        host_rd_req = 1'b0;
    logic [7:0]  host_rd_addr = '0;
    logic        host_rd_busy;
    logic [31:0] host_rd_data;
    logic        host_rd_valid;
    logic [4:0]  head_slot;
    logic [15:0] sample_cnt;
    logic        sample_done;
    logic        frame_err;

    imu_ram_writer #(.WORDS_PER_SAMPLE(WPS), .NUM_SLOTS(NS), .STARVE_LIM(4)) dut (
        .c(c), .rst(rst), .s_d(s_d), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_d(ram_d), .ram_q(ram_q),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_busy(host_rd_busy),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid), .head_slot(head_slot),
        .sample_cnt(sample_cnt), .sample_done(sample_done), .frame_err(frame_err)
    );

    always #5 c = ~c;

    logic [31:0] mem [256];
    logic [31:0] shadow [256];
    always @(posedge c) begin
        if (ram_wr) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    logic [39:0] wq [$];
    logic [31:0] hq [$];
    int nerr = 0;
    int nchk = 0;

    int   st_idx = 0, st_frame = 0;
    int   head_nxt = 0, cnt_nxt = 0, head_cur = 0, cnt_cur = 0;
    logic done_set = 1'b0, err_set = 1'b0, done_due = 1'b0, err_due = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        logic [39:0] w;
        logic [31:0] h;
        if (ram_wr !== 1'b0) begin
            if (wq.size() == 0) chk("wr_unexpected", 32'(ram_wr), 32'd0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(w[39:32]));
                chk("wr_data", ram_d, w[31:0]);
            end
        end
        if (host_rd_valid !== 1'b0) begin
            if (hq.size() == 0) chk("rd_unexpected", 32'(host_rd_valid), 32'd0);
            else begin
                h = hq.pop_front();
                chk("rd_data", host_rd_data, h);
            end
        end
        chk("sample_done", 32'(sample_done), 32'(done_due));
        chk("frame_err", 32'(frame_err), 32'(err_due));
        chk("head_slot", 32'(head_slot), 32'(head_cur));
        chk("sample_cnt", 32'(sample_cnt), 32'(cnt_cur & 16'hffff));
    endtask

    // One clock cycle: drive just after the rising edge, check at the falling edge.
    task automatic cycle(input logic v, input int flen, input logic req, input logic [7:0] raddr,
                         input logic r);
        logic [31:0] dat;
        @(posedge c);
        #1;
        head_cur = head_nxt;
        cnt_cur  = cnt_nxt;
        done_due = done_set;
        err_due  = err_set;
        done_set = 1'b0;
        err_set  = 1'b0;
        dat = 32'h100 + 32'(st_frame) * 32'h100 + 32'(st_idx);
        rst          = r;
        host_rd_req  = req;
        host_rd_addr = raddr;
        s_valid      = v;
        s_d          = v ? dat : 32'd0;
        s_last       = v && (st_idx == flen - 1);
        if (req && host_rd_busy === 1'b0) hq.push_back(shadow[raddr]);
        if (v && !r && s_ready === 1'b1) begin
            if (st_idx < WPS) begin
                wq.push_back({8'(head_nxt * WPS + st_idx), dat});
                shadow[8'(head_nxt * WPS + st_idx)] = dat;
            end
            if (st_idx == flen - 1) begin
                if (flen == WPS) begin
                    head_nxt = (head_nxt + 1) % NS;
                    cnt_nxt  = cnt_nxt + 1;
                    done_set = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
                st_idx = 0;
                st_frame++;
            end else begin
                st_idx++;
            end
        end
        if (r) begin
            head_nxt = 0;
            cnt_nxt  = 0;
            done_set = 1'b0;
            err_set  = 1'b0;
            st_idx   = 0;
            hq.delete();
        end
        @(negedge c);
        sb_check();
    endtask

    task automatic send_frame(input int flen);
        int start = st_frame;
        int g = 0;
        while (st_frame == start && g < 200) begin
            cycle(1'b1, flen, 1'b0, 8'd0, 1'b0);
            g++;
        end
        chk("frame_timeout", 32'(st_frame - start), 32'd1);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_d"}, ram_d, 32'd0);
        chk({tag, "_busy"}, 32'(host_rd_busy), 32'd0);
        chk({tag, "_rd_data"}, host_rd_data, 32'd0);
        chk({tag, "_rd_valid"}, 32'(host_rd_valid), 32'd0);
        chk({tag, "_head"}, 32'(head_slot), 32'd0);
        chk({tag, "_cnt"}, 32'(sample_cnt), 32'd0);
        chk({tag, "_done"}, 32'(sample_done), 32'd0);
        chk({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", nerr, nchk);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b1);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b1);
        chk_all_zero("reset");
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
        chk("ready_release0", 32'(s_ready), 32'd0);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
        chk("ready_release1", 32'(s_ready), 32'd1);

        send_frame(WPS);
        chk("t1_head", 32'(head_slot), 32'd1);
        chk("t1_cnt", 32'(sample_cnt), 32'd1);

        for (int i = 0; i < 31; i++) send_frame(WPS);
        chk("wrap_head0", 32'(head_slot), 32'd0);
        send_frame(WPS);
        chk("wrap_head1", 32'(head_slot), 32'd1);
        chk("wrap_cnt", 32'(sample_cnt), 32'd33);

        send_frame(3);
        chk("short_head", 32'(head_slot), 32'd1);
        send_frame(10);
        chk("long_head", 32'(head_slot), 32'd1);
        send_frame(WPS);
        chk("refill_head", 32'(head_slot), 32'd2);
        chk("refill_cnt", 32'(sample_cnt), 32'd34);

        cycle(1'b0, WPS, 1'b1, 8'd9, 1'b0);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
        chk("idle_grant_addr", 32'(ram_addr), 32'd9);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);
        chk("idle_rd_valid", 32'(host_rd_valid), 32'd1);

        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, WPS, 1'b1, 8'd5, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
            chk("starve_ready_hi", 32'(s_ready), 32'd1);
            chk("starve_busy", 32'(host_rd_busy), 32'd1);
        end
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        chk("starve_ready_lo", 32'(s_ready), 32'd0);
        chk("starve_grant_addr", 32'(ram_addr), 32'd5);
        chk("starve_grant_wr", 32'(ram_wr), 32'd0);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        chk("starve_ready_back", 32'(s_ready), 32'd1);
        chk("starve_valid_early", 32'(host_rd_valid), 32'd0);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        chk("starve_valid", 32'(host_rd_valid), 32'd1);
        chk("starve_busy_clr", 32'(host_rd_busy), 32'd0);
        g = 0;
        while (st_idx != 0 && g < 50) begin
            cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
            g++;
        end
        chk("starve_frame_end", 32'(st_idx), 32'd0);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);

        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, WPS, 1'b1, 8'd5, 1'b0);
        cycle(1'b0, WPS, 1'b0, 8'd0, 1'b1);
        cycle(1'b1, WPS, 1'b0, 8'd0, 1'b0);
        chk_all_zero("midrst");
        send_frame(WPS);
        chk("post_rst_head", 32'(head_slot), 32'd1);
        chk("post_rst_cnt", 32'(sample_cnt), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, WPS, 1'b0, 8'd0, 1'b0);

        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("hq_drained", 32'(hq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
